// File: rtl/minmax_tracker.sv
// Streaming extreme tracker: collects a frame of unsigned samples over a
// valid/ready handshake and reports the max (or min) value and its first index.
module minmax_tracker #(
  parameter int N     = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_m,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [N-1:0]     i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [N-1:0]     o_out_data,
  output logic [LEN_W-1:0] o_out_idx,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic             r_mode;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [N-1:0]     r_best;
  logic [LEN_W-1:0] r_bestIdx;
  logic [N-1:0]     r_outData;
  logic [LEN_W-1:0] r_outIdx;

  logic             w_startOk;
  logic             w_accept;
  logic             w_lastAccept;
  logic             w_better;
  logic             w_take;
  logic [N-1:0]     w_newBest;
  logic [LEN_W-1:0] w_newIdx;
  logic             w_inReady;
  logic             w_outValid;

  assign w_startOk    = (r_state == IDLE) && i_start && (i_len != '0);
  assign w_accept     = i_in_valid && w_inReady;
  assign w_lastAccept = w_accept && (r_count == (r_len - LEN_W'(1)));

  // Strict comparison so that ties keep the earlier sample.
  assign w_better  = r_mode ? (i_in_data < r_best) : (i_in_data > r_best);
  assign w_take    = (r_count == '0) || w_better;
  assign w_newBest = w_take ? i_in_data : r_best;
  assign w_newIdx  = w_take ? r_count : r_bestIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_startOk) begin
          w_nextState = COLLECT;
        end
      end
      COLLECT: begin
        w_inReady = 1'b1;
        if (w_lastAccept) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        w_outValid = 1'b1;
        if (i_out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= 1'b0;
      r_len     <= '0;
      r_count   <= '0;
      r_best    <= '0;
      r_bestIdx <= '0;
    end else begin
      if (w_startOk) begin
        r_mode  <= i_m;
        r_len   <= i_len;
        r_count <= '0;
      end else if (w_accept) begin
        r_count   <= r_count + LEN_W'(1);
        r_best    <= w_newBest;
        r_bestIdx <= w_newIdx;
      end
    end
  end

  // Result registers only load on the final sample, so they stay frozen
  // through HOLD and after the handshake until the next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData <= '0;
      r_outIdx  <= '0;
    end else if (w_lastAccept) begin
      r_outData <= w_newBest;
      r_outIdx  <= w_newIdx;
    end
  end

  assign o_in_ready  = w_inReady;
  assign o_out_valid = w_outValid;
  assign o_out_data  = r_outData;
  assign o_out_idx   = r_outIdx;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Streaming counterpart of the two-input min/max selector.
- Accepts a frame of `len` unsigned N-bit samples over a valid/ready handshake and tracks the running extreme (max or min) across the frame.
- Returns the extreme value and its sample index through a valid/ready result port.
- Sits downstream of sample producers. Replaces a tree of combinational selectors when samples arrive serially.

Parameters:
- N, 8, sample and result data width (unsigned).
- LEN_W, 4, width of the frame-length input and of the result index. Maximum frame is 2^LEN_W-1 samples.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle frame start request; sampled only in IDLE.
- m  input  1  mode, latched at start: 0 = track maximum, 1 = track minimum.
- len  input  LEN_W  number of samples in the frame, latched at start.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  N  sample value.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  extreme value of the frame.
- out_idx  output  LEN_W  zero-based index of the first sample holding that extreme.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - in_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0.
  - Internal count=0, latched mode=0, latched len=0.
  - Reset asserted mid-frame or mid-HOLD aborts immediately; the result is lost.
- States: IDLE, COLLECT, HOLD. All outputs are registered or decoded from state only; there is no combinational path from in_* to out_*.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with len!=0: latch m and len, count=0, next state COLLECT.
  - start=1 with len==0: ignored; stay in IDLE.
- COLLECT:
  - in_ready=1.
  - A sample is accepted on any cycle with in_valid & in_ready.
  - First accepted sample (count==0): best=in_data, best_idx=0, unconditionally.
  - Later samples: replace best only if strictly better.
    - Mode 0: in_data > best.
    - Mode 1: in_data < best.
    - Ties keep the earlier sample; best_idx=count.
  - Comparison is unsigned, N bits.
  - count increments on each accepted sample.
  - Accepting the sample with count==len-1 moves the state to HOLD on the next edge. in_ready drops in that same cycle.
  - in_valid gaps stall with no state change.
- HOLD:
  - out_valid=1. out_data/out_idx show best/best_idx and stay stable until handshake.
  - in_ready=0.
  - out_valid & out_ready: next state IDLE, out_valid=0 on the next cycle. out_data/out_idx hold their last value.
- Latency:
  - out_valid rises one cycle after the last sample is accepted.
  - With in_valid and out_ready held high, a frame takes len+2 cycles from the start cycle back to IDLE.
- Ignored inputs:
  - start is ignored outside IDLE.
  - Changes to m or len after the start cycle do not affect the current frame.
- len = 2^LEN_W-1 (maximum): count must not wrap before the HOLD transition. out_idx can reach len-1.

Test Plan:
- Max with tie: m=0, len=4, samples 3,9,2,9 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_data=9, out_idx=1, IDLE two cycles after the last accept.
- Min with tie and stalls: m=1, len=3, samples 5,1,1 with one idle in_valid cycle between each -> out_data=1, out_idx=1; in_ready high throughout COLLECT.
- Back-pressure: len=2, samples 0x10,0x80, m=0, out_ready low 3 cycles -> out_valid held 4 cycles, out_data=0x80 and out_idx=1 stable, in_ready=0 in HOLD, start pulses ignored.
- Edge lengths:
  - len=0 start -> busy stays 0.
  - len=1, sample 0xFF, m=1 -> out_data=0xFF, out_idx=0.
  - len=15 with ascending samples 0..14, m=0 -> out_data=14, out_idx=14.
- Latched mode: start with m=0, toggle m to 1 after start, samples 4,7 -> out_data=7, out_idx=1.
- Reset: assert rst_n=0 after 2 of 4 samples accepted -> in_ready, busy, out_valid, out_data and out_idx all 0 immediately (before the next edge). A following frame m=1, len=2, samples 6,3 -> out_data=3, out_idx=1.
